// File: rtl/psum_deskew_accum.sv
// psum_deskew_accum: removes the diagonal column skew from the bottom row of
// the systolic array, accumulates aligned rows across K-tiles in a local bank,
// and streams finished rows out through a 2-entry first-word-fall-through FIFO.
module psum_deskew_accum #(
   parameter int SYSTOLIC_SIZE     = 8,
   parameter int PARTIAL_SUM_WIDTH = 19,
   parameter int ACC_WIDTH         = 32,
   localparam int ROW_W            = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic                                   acc_clear,
   input  logic                                   tile_last,
   input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]     out_data,
   output logic [ROW_W-1:0]                       out_row,
   output logic                                   overflow
);

   localparam int N   = SYSTOLIC_SIZE;
   localparam int PSW = PARTIAL_SUM_WIDTH;
   localparam int AW  = ACC_WIDTH;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

   typedef struct packed {
      logic valid;
      logic clear;
      logic last;
   } ctl_t;

   // Deskew delay lines
   logic [PSW-1:0] lane_pre [N];
   ctl_t           ctl_sr   [N-1];

   // Aligned stage
   ctl_t           al_ctl;
   logic [PSW-1:0] al_lane  [N];

   // Accumulator bank
   logic [AW-1:0]    acc [N][N];
   logic [ROW_W-1:0] row_q;
   logic [N*AW-1:0]  sum_flat;

   // Output FIFO: head register plus one spare entry
   logic             head_valid, tail_valid;
   logic [N*AW-1:0]  head_data, tail_data;
   logic [ROW_W-1:0] head_row, tail_row;
   logic             push, pop, push_ok;

   // Column c waits N-1-c cycles so every column reaches the aligned stage together
   for (genvar c = 0; c < N; c++) begin : g_col
      localparam int D = N - 1 - c;
      if (D == 0) begin : g_nodly
         assign lane_pre[c] = psum_in[c*PSW +: PSW];
      end else begin : g_dly
         logic [PSW-1:0] sr [D];
         // Shift this column's delay line every cycle
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < D; i++) sr[i] <= '0;
            end else begin
               sr[0] <= psum_in[c*PSW +: PSW];
               for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
         end
         assign lane_pre[c] = sr[D-1];
      end
   end

   // Carry the control bits alongside column 0's delay
   // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N-1; i++) ctl_sr[i] <= '0;
      end else begin
         ctl_sr[0] <= {in_valid, acc_clear, tile_last};
         for (int i = 1; i < N-1; i++) ctl_sr[i] <= ctl_sr[i-1];
      end
   end

   // Aligned register: all lanes and control for one row land here together
   always_ff @(posedge clk) begin
      if (rst) begin
         al_ctl <= '0;
         for (int c = 0; c < N; c++) al_lane[c] <= '0;
      end else begin
         al_ctl <= ctl_sr[N-2];
         for (int c = 0; c < N; c++) al_lane[c] <= lane_pre[c];
      end
   end

   // New row value: overwrite on the first K-tile, otherwise add (wraps modulo 2^AW)
   always_comb begin
      // NOTE: default first so no path through this block can leave sum_flat unassigned (no latch).
      sum_flat = '0;
      for (int c = 0; c < N; c++) begin
         sum_flat[c*AW +: AW] = al_ctl.clear
            ? {{(AW-PSW){1'b0}}, al_lane[c]}
            : acc[row_q][c] + {{(AW-PSW){1'b0}}, al_lane[c]};
      end
   end

   // Write the accumulator row and advance the row counter on every aligned beat
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bank is reset because a fresh tile sequence after rst must see zeros, not stale sums.
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) acc[r][c] <= '0;
         row_q <= '0;
      end else if (al_ctl.valid) begin
         for (int c = 0; c < N; c++) acc[row_q][c] <= sum_flat[c*AW +: AW];
         row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end
   end

   assign push    = al_ctl.valid & al_ctl.last;
   assign pop     = head_valid & out_ready;
   // A pop in the same cycle always frees a slot, even when full
   assign push_ok = push & (~tail_valid | pop);

   // FIFO update: pop first, then place the push in whichever slot is free after it
   always_ff @(posedge clk) begin
      if (rst) begin
         head_valid <= 1'b0;
         tail_valid <= 1'b0;
         head_data  <= '0;
         tail_data  <= '0;
         head_row   <= '0;
         tail_row   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (pop) begin
            if (tail_valid) begin
               head_data  <= tail_data;
               head_row   <= tail_row;
               tail_valid <= 1'b0;
            end else begin
               head_valid <= 1'b0;
            end
         end
         if (push_ok) begin
            if (!head_valid || (pop && !tail_valid)) begin
               head_data  <= sum_flat;
               head_row   <= row_q;
               head_valid <= 1'b1;
            end else begin
               tail_data  <= sum_flat;
               tail_row   <= row_q;
               tail_valid <= 1'b1;
            end
         end
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   assign out_valid = head_valid;
   assign out_data  = head_data;
   assign out_row   = head_row;

endmodule

// File: tb/tb_psum_deskew_accum.sv
// Directed testbench for psum_deskew_accum: skew alignment, multi-tile
// accumulation, modular wrap, FIFO backpressure/overflow, and mid-pipe reset.
module tb_psum_deskew_accum;

   localparam int N   = 8;
   localparam int PSW = 19;
   localparam int AW  = 32;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              acc_clear;
   logic              tile_last;
   logic [N*PSW-1:0]  psum_in;
   logic              out_valid;
   logic              out_ready;
   logic [N*AW-1:0]   out_data;
   logic [2:0]        out_row;
   logic              overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit saw;

   // Column values scheduled for future cycles (slot = cycle mod 64)
   logic [PSW-1:0] pend [64][N];
   logic [PSW-1:0] beat [N];
   logic [N*AW-1:0] exp_data;

   psum_deskew_accum #(
      .SYSTOLIC_SIZE    (N),
      .PARTIAL_SUM_WIDTH(PSW),
      .ACC_WIDTH        (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .acc_clear(acc_clear),
      .tile_last(tile_last),
      .psum_in  (psum_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_row  (out_row),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: optionally launch a beat (column c delivered c cycles later), then sample #1 after the edge
   task automatic tick(input bit v, input bit clr, input bit lst);
      int slot;
      if (v) for (int c = 0; c < N; c++) pend[(cyc + c) % 64][c] = beat[c];
      slot      = cyc % 64;
      in_valid  = v;
      acc_clear = clr;
      tile_last = lst;
      for (int c = 0; c < N; c++) psum_in[c*PSW +: PSW] = pend[slot][c];
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) pend[slot][c] = '0;
      cyc++;
   endtask

   task automatic set_beat_all(input logic [PSW-1:0] v);
      for (int c = 0; c < N; c++) beat[c] = v;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick(0, 0, 0);
      rst = 1'b0;
   endtask

   function automatic logic [N*AW-1:0] rep(input logic [AW-1:0] v);
      return {N{v}};
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      acc_clear = 1'b0;
      tile_last = 1'b0;
      out_ready = 1'b0;
      psum_in   = '0;
      for (int s = 0; s < 64; s++)
         for (int c = 0; c < N; c++) pend[s][c] = '0;
      for (int c = 0; c < N; c++) beat[c] = '0;

      // ---- Reset state ----
      tick(0, 0, 0);
      tick(0, 0, 0);
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_row",   out_row,   0);
      check("rst_overflow",  overflow,  0);

      // ---- Skew alignment: lane c = 100+c, single tile ----
      out_ready = 1'b1;
      for (int c = 0; c < N; c++) beat[c] = PSW'(100 + c);
      tick(1, 1, 1);                                  // cycle T
      for (int i = 0; i < 7; i++) tick(0, 0, 0);      // now at T+8
      check("skew_not_early", out_valid, 0);
      tick(0, 0, 0);                                  // T+9
      check("skew_valid", out_valid, 1);
      check("skew_row",   out_row,   0);
      for (int c = 0; c < N; c++) exp_data[c*AW +: AW] = AW'(100 + c);
      check("skew_data",  out_data,  exp_data);
      tick(0, 0, 0);
      check("skew_popped", out_valid, 0);

      // ---- Two-tile accumulate on row 0: 5 + 7 = 12 ----
      reset_pulse();
      saw = 0;
      set_beat_all(19'd5);
      tick(1, 1, 0);                                  // row 0, tile A
      if (out_valid) saw = 1;
      set_beat_all(19'd0);
      for (int r = 1; r < N; r++) begin
         tick(1, 1, 0);                               // rows 1..7
         if (out_valid) saw = 1;
      end
      set_beat_all(19'd7);
      tick(1, 0, 1);                                  // row 0 again, tile B (T)
      if (out_valid) saw = 1;
      for (int i = 0; i < 7; i++) begin
         tick(0, 0, 0);
         if (out_valid) saw = 1;
      end
      check("acc2_no_early_out", saw, 0);
      tick(0, 0, 0);                                  // T+9
      check("acc2_valid", out_valid, 1);
      check("acc2_row",   out_row,   0);
      check("acc2_data",  out_data,  rep(32'd12));
      tick(0, 0, 0);

      // ---- Modular wrap: row 0 reaches 0xFFFF_FFF0, then +0x20 -> 0x10 ----
      reset_pulse();
      saw = 0;
      for (int r = 0; r < 8193; r++) begin
         set_beat_all((r < 8192) ? 19'h7FFFF : 19'h01FF0);
         for (int k = 0; k < N; k++) begin
            tick(1, r == 0, 0);
            if (out_valid) saw = 1;
         end
      end
      set_beat_all(19'h00020);
      tick(1, 0, 1);
      for (int i = 0; i < 7; i++) begin
         tick(0, 0, 0);
         if (out_valid) saw = 1;
      end
      check("wrap_no_early_out", saw, 0);
      tick(0, 0, 0);
      check("wrap_valid",    out_valid, 1);
      check("wrap_row",      out_row,   0);
      check("wrap_data",     out_data,  rep(32'h0000_0010));
      check("wrap_no_flag",  overflow,  0);
      tick(0, 0, 0);

      // ---- Backpressure and overflow: three pushes, ready low ----
      reset_pulse();
      out_ready = 1'b0;
      set_beat_all(19'd1); tick(1, 1, 1);             // T,   row 0
      set_beat_all(19'd2); tick(1, 1, 1);             // T+1, row 1
      set_beat_all(19'd3); tick(1, 1, 1);             // T+2, row 2
      for (int i = 0; i < 6; i++) tick(0, 0, 0);      // T+9
      check("bp_valid_t9",  out_valid, 1);
      check("bp_row_t9",    out_row,   0);
      check("bp_data_t9",   out_data,  rep(32'd1));
      check("bp_ovf_t9",    overflow,  0);
      tick(0, 0, 0);                                  // T+10
      check("bp_row_t10",   out_row,   0);
      check("bp_ovf_t10",   overflow,  0);
      tick(0, 0, 0);                                  // T+11
      check("bp_ovf_t11",   overflow,  1);
      check("bp_row_t11",   out_row,   0);
      out_ready = 1'b1;
      tick(0, 0, 0);                                  // T+12
      check("bp_drain_valid", out_valid, 1);
      check("bp_drain_row",   out_row,   1);
      check("bp_drain_data",  out_data,  rep(32'd2));
      tick(0, 0, 0);                                  // T+13
      check("bp_empty",       out_valid, 0);
      check("bp_ovf_sticky",  overflow,  1);

      // ---- Full FIFO with push and pop in the same cycle ----
      reset_pulse();
      check("pp_ovf_cleared", overflow, 0);
      out_ready = 1'b0;
      set_beat_all(19'd1); tick(1, 1, 1);
      set_beat_all(19'd2); tick(1, 1, 1);
      set_beat_all(19'd3); tick(1, 1, 1);
      for (int i = 0; i < 7; i++) tick(0, 0, 0);      // T+10: FIFO full, third push due
      check("pp_head_row0", out_row, 0);
      out_ready = 1'b1;
      tick(0, 0, 0);                                  // T+11
      check("pp_no_ovf",    overflow,  0);
      check("pp_row1",      out_row,   1);
      check("pp_data1",     out_data,  rep(32'd2));
      tick(0, 0, 0);                                  // T+12
      check("pp_valid2",    out_valid, 1);
      check("pp_row2",      out_row,   2);
      check("pp_data2",     out_data,  rep(32'd3));
      tick(0, 0, 0);                                  // T+13
      check("pp_empty",     out_valid, 0);
      check("pp_no_ovf_end", overflow, 0);

      // ---- Reset with four beats in flight ----
      reset_pulse();
      out_ready = 1'b1;
      set_beat_all(19'd9);
      for (int i = 0; i < 4; i++) tick(1, 1, 1);
      reset_pulse();
      saw = 0;
      for (int i = 0; i < 12; i++) begin
         tick(0, 0, 0);
         if (out_valid) saw = 1;
      end
      check("rstmid_no_out", saw, 0);
      for (int c = 0; c < N; c++) beat[c] = PSW'(40 + c);
      tick(1, 1, 1);
      for (int i = 0; i < 8; i++) tick(0, 0, 0);
      check("rstmid_valid", out_valid, 1);
      check("rstmid_row",   out_row,   0);
      for (int c = 0; c < N; c++) exp_data[c*AW +: AW] = AW'(40 + c);
      check("rstmid_data",  out_data,  exp_data);
      check("rstmid_ovf",   overflow,  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_deskew_accum.md
Name: psum_deskew_accum

Overview:
- Sits directly below the bottom row of the systolic PE array and consumes the partial_sum_out bus of every column.
- Column c of the array delivers its result for a given activation vector c cycles after column 0. This block removes that diagonal skew with per-column delay lines.
- It then accumulates aligned rows across K-tiles in a local accumulator bank. On the last tile it emits finished output rows through a valid/ready stream backed by a 2-entry FIFO.
- The array cannot stall, so the input side has no backpressure. Output overflow is flagged, never back-propagated.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension: number of columns, and number of rows in the accumulator bank.
- PARTIAL_SUM_WIDTH, 19, width of one column's partial sum. Equals 8+8+log2(8) for the default array.
- ACC_WIDTH, 32, width of one accumulator entry and of one output lane.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  column 0 carries a valid result this cycle; column c carries the same row's result c cycles later.
- acc_clear  in  1  sampled with in_valid: this row is the first K-tile, so overwrite the accumulator instead of adding.
- tile_last  in  1  sampled with in_valid: this row is the final K-tile, so push the accumulated row to the output FIFO.
- psum_in  in  SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH  bottom-row partial sums; column c occupies bits [c*PSW +: PSW].
- out_valid  out  1  FIFO head holds a finished row.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- out_data  out  SYSTOLIC_SIZE*ACC_WIDTH  finished row; lane c occupies [c*ACC_WIDTH +: ACC_WIDTH].
- out_row  out  log2(SYSTOLIC_SIZE)  accumulator row index of out_data.
- overflow  out  1  sticky: a push was attempted into a full FIFO.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears the following; rst has priority over all other events, including mid-pipeline:
  - all deskew data and control valid bits to 0;
  - accumulator bank to 0;
  - row counter to 0;
  - FIFO to empty;
  - out_valid=0, out_data=0, out_row=0, overflow=0.
- Deskew:
  - Column c is delayed by SYSTOLIC_SIZE-1-c registers. Column SYSTOLIC_SIZE-1 has no delay.
  - in_valid, acc_clear and tile_last are captured at cycle T and delayed SYSTOLIC_SIZE-1 registers.
  - All lanes plus control land together in one aligned register, valid during cycle T+SYSTOLIC_SIZE.
  - Column c data is sampled at cycle T+c, independent of in_valid at that cycle.
  - Delay registers shift every cycle; there is no enable.
- Accumulate (aligned stage, aligned_valid=1):
  - r = row counter.
  - Each lane is zero-extended to ACC_WIDTH.
  - sum[c] = acc_clear ? lane[c] : acc[r][c] + lane[c], modulo 2^ACC_WIDTH. No saturation.
  - acc[r] <= sum at the end of cycle T+SYSTOLIC_SIZE.
  - Row counter increments and wraps from SYSTOLIC_SIZE-1 to 0.
- Emit:
  - If tile_last is set at the aligned stage, {sum, r} is pushed into the FIFO at the same edge as the accumulator write.
  - out_valid is therefore first high in cycle T+SYSTOLIC_SIZE+1. Latency is SYSTOLIC_SIZE+1 cycles from column-0 capture (9 at default).
- FIFO:
  - Depth 2, first-word fall-through. out_data and out_row are the head entry while out_valid=1.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are always legal, including when full: the pop frees a slot and the push is accepted.
  - Push into a full FIFO with no pop: the entry is dropped, overflow is set and held until rst, and the accumulator is still written.
  - While out_valid=0, out_data and out_row hold their last value and carry no meaning.
- Back-to-back in_valid every cycle is supported at full throughput; pushes then occur every cycle.
- acc_clear and tile_last together (single-tile K) output the raw lane values.

Test Plan:
- Skew alignment: in_valid at T with column c = 100+c delivered at T+c, acc_clear=1, tile_last=1, out_ready=1 -> out_valid in cycle T+9, lane c = 100+c, out_row=0.
- Two-tile accumulate: row 0 tile A, all lanes 5, acc_clear=1; later row 0 tile B, all lanes 7, tile_last=1 (row counter wrapped after 8 beats) -> row 0 output lanes = 12; no output after tile A.
- Wrap and width: acc preloaded to 0xFFFF_FFF0 through repeated tiles, then add lane 0x20 -> lane = 0x0000_0010, no flag.
- Backpressure and overflow: out_ready=0, 3 consecutive tile_last rows -> first 2 held in order (out_row 0, 1), third dropped, overflow=1 from the next cycle; then out_ready=1 -> rows 0 and 1 drain, overflow stays 1.
- Full-FIFO push+pop same cycle: FIFO full, out_ready=1, push arrives -> no overflow, order preserved.
- Reset mid-operation: rst=1 for 1 cycle while 4 beats are in the deskew pipe -> no out_valid afterwards; a new single-tile row emits out_row=0 with exactly its own lane values.
